// File: rtl/fsm_pkg.sv
// Shared FSM state encodings for the input-conditioning front end:
// the debouncer and the downstream edge detector.
package fsm_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } deb_state_t;

  typedef enum logic [1:0] {
    E_IDLE   = 2'd0,
    E_ARMED  = 2'd1,
    E_STROBE = 2'd2
  } edge_state_t;

  function automatic logic is_wait_state(input deb_state_t st);
    return (st == S_WAIT_HIGH) || (st == S_WAIT_LOW);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop synchroniser for a single asynchronous bit; plain shift chain with
// no logic between stages.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic in_clk,
  input  logic in_rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronises a raw input and debounces it with a counter-qualified Moore
// FSM; provides the clean level, registered edge strobes and a busy flag.
module debounce_sync
  import fsm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic in_clk,
  input  logic in_rst_n,
  input  logic in_i,
  output logic o_q,
  output logic o_rise,
  output logic o_fall,
  output logic o_busy
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise_nxt, fall_nxt;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .d        (in_i),
    .q        (s)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state  <= S_LOW;
      cnt    <= '0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      o_rise <= rise_nxt;
      o_fall <= fall_nxt;
    end
  end

  // Entering a WAIT state is the first sample of the new level, so the
  // accept at cnt==CNT_MAX is the (DEBOUNCE_CYCLES+1)th consecutive sample.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      S_LOW: begin
        if (s) begin
          state_nxt = S_WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!s) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!s) begin
          state_nxt = S_WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      S_WAIT_LOW: begin
        if (s) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign o_q    = (state == S_HIGH) || (state == S_WAIT_LOW);
  assign o_busy = is_wait_state(state);

endmodule

// File: tb/tb_debounce_sync.sv
// Directed-vector bench for debounce_sync at default parameters, with a
// run-length reference model cross-checking o_q every cycle.
module tb_debounce_sync;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic in_i;
  logic o_q, o_rise, o_fall, o_busy;

  int n_vec  = 0;
  int n_fail = 0;

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(D)) dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .in_i     (in_i),
    .o_q      (o_q),
    .o_rise   (o_rise),
    .o_fall   (o_fall),
    .o_busy   (o_busy)
  );

  always #10 clk = ~clk;

  // One row per posedge: input driven before the edge, outputs {q,rise,fall,busy} expected 1 ns after it.
  typedef struct {
    logic       i;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic i, input logic [3:0] exp, input int reps = 1);
    vec_t v;
    v.i   = i;
    v.exp = exp;
    for (int r = 0; r < reps; r++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {o_q, o_rise, o_fall, o_busy};
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: {q,rise,fall,busy} got %b expected %b @%0t", name, act, exp, $time);
    end
  endtask

  task automatic run_table(input string tag);
    for (int k = 0; k < tbl.size(); k++) begin
      in_i = tbl[k].i;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", tag, k), tbl[k].exp);
    end
    tbl.delete();
  endtask

  // Reference: o_q flips once the synchronised input has differed from it on D+1 consecutive edges.
  logic [1:0] m_sync;
  logic       m_q;
  int         m_run;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync <= '0;
      m_q    <= 1'b0;
      m_run  <= 0;
    end else begin
      m_sync <= {m_sync[0], in_i};
      if (m_sync[1] != m_q) begin
        if (m_run == D) begin
          m_q   <= m_sync[1];
          m_run <= 0;
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
    end
  end

  logic prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_vec++;
      if (o_q !== m_q) begin
        n_fail++;
        $display("FAIL scoreboard_q: o_q got %b expected %b @%0t", o_q, m_q, $time);
      end
      n_vec++;
      if ((o_rise && o_fall) || (prev_strobe && (o_rise || o_fall))) begin
        n_fail++;
        $display("FAIL strobe_excl: rise=%b fall=%b prev=%b expected exclusive, non-consecutive @%0t",
                 o_rise, o_fall, prev_strobe, $time);
      end
      prev_strobe <= o_rise | o_fall;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_i  = 1'b0;
    #5;
    check("in_reset", 4'b0000);
    #10;
    rst_n = 1'b1;

    add(0, 4'b0000, 10);
    run_table("idle");

    // D-cycle pulse: enters WAIT_HIGH, reverts before acceptance.
    add(1, 4'b0000, 2);
    add(1, 4'b0001, 2);
    add(0, 4'b0001, 2);
    add(0, 4'b0000, 2);
    run_table("pulse4");

    // Steady rise, then steady fall; both accepted on the 7th edge.
    add(1, 4'b0000, 2);
    add(1, 4'b0001, 4);
    add(1, 4'b1100);
    add(1, 4'b1000);
    run_table("rise");
    add(0, 4'b1000, 2);
    add(0, 4'b1001, 4);
    add(0, 4'b0010);
    add(0, 4'b0000);
    run_table("fall");

    // (D+1)-cycle pulse: accepted, then falls back after its own qualification.
    add(1, 4'b0000, 2);
    add(1, 4'b0001, 3);
    add(0, 4'b0001);
    add(0, 4'b1100);
    add(0, 4'b1001, 4);
    add(0, 4'b0010);
    add(0, 4'b0000);
    run_table("pulse5");

    // Bounce 1,0,1,0,1 then steady 1: one rise, 7 edges after the last 0->1.
    add(1, 4'b0000);
    add(0, 4'b0000);
    add(1, 4'b0001);
    add(0, 4'b0000);
    add(1, 4'b0001);
    add(1, 4'b0000);
    add(1, 4'b0001, 4);
    add(1, 4'b1100);
    add(1, 4'b1000);
    run_table("bounce");

    add(0, 4'b1000, 2);
    add(0, 4'b1001, 4);
    add(0, 4'b0010);
    add(0, 4'b0000);
    run_table("fall2");

    // Reset pulse while in WAIT_HIGH with cnt=2.
    add(1, 4'b0000, 2);
    add(1, 4'b0001, 3);
    run_table("pre_rst");
    n_vec++;
    if (dut.cnt !== 2) begin
      n_fail++;
      $display("FAIL cnt_before_rst: got %0d expected 2", dut.cnt);
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst", 4'b0000);
    n_vec++;
    if (dut.cnt !== 0) begin
      n_fail++;
      $display("FAIL cnt_in_rst: got %0d expected 0", dut.cnt);
    end
    rst_n = 1'b1;
    add(1, 4'b0000, 2);
    add(1, 4'b0001, 4);
    add(1, 4'b1100);
    add(1, 4'b1000);
    run_table("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
